// File: rtl/onehot2bin_pipe.sv
// ============================================================================
// Module   : onehot2bin_pipe
// Brief    : Registered one-hot-to-binary decoder with malformed-word flag,
//            saturating error counter and a 2-entry valid/ready skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot2bin_pipe #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [2**W-2:0]      in,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [W-1:0]         out,
    output logic                 out_err,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     err_count
);

    localparam int N = 2**W - 1;

    // State bits mirror {out_valid, skid_valid}.
    localparam logic [1:0] S_EMPTY = 2'b00;
    localparam logic [1:0] S_HALF  = 2'b10;
    localparam logic [1:0] S_FULL  = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [W-1:0]     out_q, skid_q;
    logic             out_err_q, skid_err_q;
    logic [CNT_W-1:0] cnt_q;

    logic [W-1:0]     dec_idx;
    logic             dec_seen, dec_multi, dec_err;
    logic             accept, xfer;
    logic             load_main_in, load_main_skid, load_skid;

    // Lowest set index wins; an empty word decodes to all ones.
    always_comb begin
        dec_idx   = {W{1'b1}};
        dec_seen  = 1'b0;
        dec_multi = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (in[k]) begin
                dec_idx = k[W-1:0];
            end
        end
        for (int k = 0; k < N; k++) begin
            if (in[k]) begin
                if (dec_seen) begin
                    dec_multi = 1'b1;
                end
                dec_seen = 1'b1;
            end
        end
        dec_err = ~dec_seen | dec_multi;
    end

    assign in_ready  = rst & (state_q != S_FULL);
    assign out_valid = state_q[1];
    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (accept) state_d = S_HALF;
            S_HALF: begin
                if (accept && !xfer) begin
                    state_d = S_FULL;
                end else if (!accept && xfer) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL:  if (xfer) state_d = S_HALF;
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            S_EMPTY: load_main_in = accept;
            S_HALF: begin
                load_main_in = accept & xfer;
                load_skid    = accept & ~xfer;
            end
            S_FULL:  load_main_skid = xfer;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q      <= '0;
            out_err_q  <= 1'b0;
            skid_q     <= '0;
            skid_err_q <= 1'b0;
        end else begin
            if (load_main_in) begin
                out_q     <= dec_idx;
                out_err_q <= dec_err;
            end else if (load_main_skid) begin
                out_q     <= skid_q;
                out_err_q <= skid_err_q;
            end
            if (load_skid) begin
                skid_q     <= dec_idx;
                skid_err_q <= dec_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (accept && dec_err && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign out       = out_q;
    assign out_err   = out_err_q;
    assign err_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_onehot2bin_pipe.sv
// ============================================================================
// Module   : tb_onehot2bin_pipe
// Brief    : Self-checking bench for onehot2bin_pipe: queue reference model
//            checked every cycle plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_onehot2bin_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [14:0] in;
    logic        in_ready;
    logic        out_valid;
    logic [3:0]  out;
    logic        out_err;
    logic        out_ready;
    logic [7:0]  err_count;

    int n_chk;
    int n_fail;
    bit mon_en;

    logic [4:0] mq[$];   // {err, idx} in acceptance order
    int         mcnt;

    onehot2bin_pipe #(.W(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in        (in),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out       (out),
        .out_err   (out_err),
        .out_ready (out_ready),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] model_dec(input logic [14:0] x);
        logic [14:0] low;
        logic [3:0]  idx;
        if (x == 15'd0) return {1'b1, 4'hF};
        low = x & (~x + 15'd1);
        idx = 4'd0;
        for (int i = 0; i < 15; i++) if (low[i]) idx = 4'(i);
        return {($countones(x) != 1), idx};
    endfunction

    // Inputs change 1 time unit after posedge; negedge sees a stable cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_in_ready", 32'(in_ready), 32'(rst && mq.size() < 2));
            chk("mon_out_valid", 32'(out_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("mon_out", 32'(out), 32'(mq[0][3:0]));
                chk("mon_out_err", 32'(out_err), 32'(mq[0][4]));
            end
            chk("mon_err_count", 32'(err_count), 32'(mcnt));
        end
        if (!rst) begin
            mq.delete();
            mcnt = 0;
        end else begin
            logic       acc;
            logic [4:0] d;
            acc = in_valid && (mq.size() < 2);
            d   = model_dec(in);
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(d);
                if (d[4] && mcnt < 255) mcnt++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [14:0] bad [3];
        logic [3:0]  bad_idx [3];
        n_chk = 0; n_fail = 0; mon_en = 0;
        rst = 1'b0; in_valid = 1'b0; in = '0; out_ready = 1'b1;
        cyc();
        mon_en = 1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        rst = 1'b1;

        // Walking one-hot, back-to-back
        in_valid = 1'b1;
        in = 15'd1;
        for (int k = 0; k < 15; k++) begin
            cyc();
            chk("walk_out", 32'(out), 32'(k));
            chk("walk_err", 32'(out_err), 32'd0);
            chk("walk_ready", 32'(in_ready), 32'd1);
            in = 15'd1 << (k + 1);
        end
        chk("walk_cnt", 32'(err_count), 32'd0);

        // Malformed words
        bad[0] = 15'h0000; bad_idx[0] = 4'd15;
        bad[1] = 15'h0014; bad_idx[1] = 4'd2;
        bad[2] = 15'h4001; bad_idx[2] = 4'd0;
        for (int i = 0; i < 3; i++) begin
            in = bad[i];
            cyc();
            chk("bad_out", 32'(out), 32'(bad_idx[i]));
            chk("bad_err", 32'(out_err), 32'd1);
            chk("bad_cnt", 32'(err_count), 32'(i + 1));
        end
        in_valid = 1'b0;
        cyc();

        // Back-pressure: 3, 7, 9 with sink stalled
        out_ready = 1'b0;
        in_valid = 1'b1;
        in = 15'd1 << 3;
        cyc();
        chk("bp_ready_half", 32'(in_ready), 32'd1);
        in = 15'd1 << 7;
        cyc();
        chk("bp_ready_full", 32'(in_ready), 32'd0);
        chk("bp_hold0", 32'(out), 32'd3);
        in = 15'd1 << 9;
        cyc();
        cyc();
        chk("bp_hold1", 32'(out), 32'd3);
        chk("bp_ready_stall", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        cyc();
        chk("bp_out7", 32'(out), 32'd7);
        cyc();
        chk("bp_out9", 32'(out), 32'd9);
        in_valid = 1'b0;
        cyc();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Reset while FULL with a word offered
        out_ready = 1'b0;
        in_valid = 1'b1;
        in = 15'd1 << 5;
        cyc();
        in = 15'd1 << 6;
        cyc();
        chk("mid_full", 32'(in_ready), 32'd0);
        rst = 1'b0;
        in = 15'd1 << 4;
        #1;
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        cyc();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_cnt", 32'(err_count), 32'd0);
        chk("mid_ready", 32'(in_ready), 32'd1);
        cyc();
        chk("mid_no4", 32'(out_valid), 32'd0);

        // Random valid/ready traffic
        for (int c = 0; c < 10000; c++) begin
            int sel;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            sel = $urandom_range(0, 9);
            if (sel < 7)       in = 15'd1 << $urandom_range(0, 14);
            else if (sel == 7) in = 15'd0;
            else               in = 15'($urandom);
            cyc();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc();
        cyc();

        // Saturation: fresh counter, 300 empty words
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        in_valid = 1'b1;
        in = 15'd0;
        for (int i = 0; i < 300; i++) begin
            cyc();
            if (i == 254) chk("sat_reach", 32'(err_count), 32'd255);
        end
        chk("sat_hold", 32'(err_count), 32'd255);
        in_valid = 1'b0;
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/onehot2bin_pipe.md
# onehot2bin_pipe

Registered one-hot-to-binary stage sitting directly downstream of `enc_bin2onehot`. It consumes the 15-bit one-hot word that the encoder produces and recovers the 4-bit index. It flags malformed words (zero bits set, or more than one bit set) and keeps a saturating count of them. A 2-entry skid buffer with valid/ready handshaking decouples it from the sink.

## Interface
Parameters:
- `W`, default 4: binary index width. The one-hot width is `N = 2**W - 1` (15 at the default).
- `CNT_W`, default 8: width of the error counter.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-low reset (0 = reset). Sampled only on the rising edge of `clk`.
- `in_valid`  input  1  upstream word valid.
- `in`  input  N  one-hot word. Bit k set means index k.
- `in_ready`  output  1  stage can accept. Defined as `rst & ~skid_valid` (combinational from state).
- `out_valid`  output  1  output word valid (registered).
- `out`  output  W  decoded index (registered).
- `out_err`  output  1  malformed-word flag travelling with `out` (registered).
- `out_ready`  input  1  downstream accepts.
- `err_count`  output  CNT_W  saturating count of accepted malformed words (registered).

## Operation
- **Accept:** an input is accepted when `in_valid & in_ready` on a rising edge. Output transfer occurs when `out_valid & out_ready`.
- **Decode (combinational, applied at accept):**
  - Exactly one bit k set: `out=k`, `err=0`.
  - No bits set: `out={W{1'b1}}` (15), `err=1`.
  - Two or more bits set: `out` = lowest set index, `err=1`.
- **Storage:** a main register (`out_valid`/`out`/`out_err`) plus one skid register (`skid_valid`, data, err).
- **States**, with S = {out_valid, skid_valid}:
  - EMPTY (0,0): an accept loads main. Result is HALF.
  - HALF (1,0):
    - Accept with transfer: main reloads with the new word; stays HALF.
    - Accept without transfer: new word goes to skid. Result is FULL.
    - Transfer only: result is EMPTY.
  - FULL (1,1): `in_ready=0`. On transfer, skid moves to main and skid clears. Result is HALF.
  - (0,1) is unreachable.
- **Ordering:** words leave in acceptance order. None are dropped or duplicated.
- **Error counter:**
  - Increments by 1 on each accepted word with `err=1`.
  - Saturates at `2**CNT_W-1` (255) and holds there.
  - Not affected by downstream stalls. Cleared only by reset.
- **Input changes while stalled:** `in` changes while `in_ready=0` have no effect.

## Timing
- **Reset** (`rst=0` at a rising edge):
  - `out_valid=0`, `out=0`, `out_err=0`, `skid_valid=0`, `err_count=0`.
  - `in_ready=0` while `rst=0`.
  - A word presented during a reset cycle is not accepted and is not counted.
  - Reset mid-operation discards both buffered entries. The first cycle after release is EMPTY with `in_ready=1`.
- **Latency:** a word accepted at edge t appears on `out` with `out_valid=1` after edge t when the stage was EMPTY, or HALF with a simultaneous transfer.
- **Throughput:** 1 word/cycle while `out_ready=1`.
- **Back-pressure:** with `out_ready=0` the stage absorbs at most 2 words. `in_ready` falls in the cycle after the second accept. It rises in the cycle after the first transfer out of FULL.
- **Holding:** `out`/`out_err` are stable while `out_valid & ~out_ready`.
- **`err_count` timing:** updates on the same edge as the accept of the malformed word.

## Test plan
- **Walking one-hot:** reset, `out_ready=1`, feed `in=1<<k` for k=0..14 back-to-back. Required: `out`=0..14 one cycle later each, `out_err=0`, `err_count=0`, `in_ready` constantly 1.
- **Malformed words:** feed 15'h0000, then 15'h0014, then 15'h4001. Required: out/err pairs (15,1), (2,1), (0,1); `err_count` goes 1, 2, 3 on the accept edges.
- **Back-pressure:**
  - `out_ready=0`, feed indices 3, 7, 9 continuously. Required: 3 and 7 accepted, `in_ready=0` from the third cycle, `out` holds 3.
  - Raise `out_ready`. Required: outputs 3, 7, 9 in order, no loss or duplication.
- **Saturation:** with `CNT_W=8`, feed 300 all-zero words. Required: `err_count` stops at 255 and stays at 255 on further errors.
- **Reset mid-operation:** fill the stage to FULL (indices 5, 6), then assert `rst=0` for 1 cycle with `in_valid=1`, `in=1<<4`. Required: after release, `out_valid=0`, `err_count=0`, `in_ready=1`, and index 4 not emitted.
- **Simultaneous accept and transfer in HALF:** stream random valid/ready patterns for 10k cycles against a reference queue model. Required: output sequence equals the accepted input sequence, and `err_count` equals the count of malformed accepts, capped at 255.
